// File: rtl/md_unit.sv
// rtl/md_unit.sv - execute-stage multiply/divide unit with HI/LO registers
//
// Purpose:
//    Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and
//    handles MTHI/MTLO as single-edge writes. The result is computed when the
//    op is accepted, parked in hi_n/lo_n, and committed to HI/LO when the
//    latency counter expires.
//
// Ports:
//    Clk       in   1   clock
//    Reset     in   1   synchronous, active-high reset (also aborts an op)
//    Start     in   1   E-stage instruction is an md op; qualifies Op
//    Op        in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//    A         in   32  forwarded rs value
//    B         in   32  forwarded rt value
//    Busy      out  1   multi-cycle operation in progress
//    StallReq  out  1   Busy, or a mult/div presented this cycle
//    HI        out  32  HI register
//    LO        out  32  LO register

module md_unit #(
   parameter int MUL_CYCLES     = 5,
   parameter int DIV_CYCLES     = 10,
   // Flags Start arriving while Busy; clear it where that traffic is intended.
   parameter bit CHK_START_BUSY = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic        StallReq,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   hi_n_q, hi_n_d;
   logic [31:0]   lo_n_q, lo_n_d;

   logic        md_start;
   logic [63:0] prod_s, prod_u;
   logic        div_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag;
   logic [31:0] div_quot, div_rem;

   assign md_start = Start && (Op >= OP_MULT) && (Op <= OP_DIVU);

   // Full 64-bit products; sign extension gives the signed product in the low
   // 64 bits of the 64x64 multiply.
   assign prod_u = {32'd0, A} * {32'd0, B};
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

   // Signed divide via magnitudes: quotient truncates toward zero and the
   // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
   // as 0x80000000 rem 0 because the magnitude 0x80000000 is unsigned here.
   always_comb begin
      div_signed = (Op == OP_DIV);
      a_neg      = div_signed && A[31];
      b_neg      = div_signed && B[31];
      a_mag      = a_neg ? (32'd0 - A) : A;
      b_mag      = b_neg ? (32'd0 - B) : B;
      q_mag      = 32'd0;
      r_mag      = 32'd0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      if (B == 32'd0) begin
         div_quot = 32'hFFFF_FFFF;
         div_rem  = A;
      end else begin
         div_quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
         div_rem  = a_neg ? (32'd0 - r_mag) : r_mag;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_n_d  = hi_n_q;
      lo_n_d  = lo_n_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               case (Op)
                  OP_MULT: begin
                     {hi_n_d, lo_n_d} = prod_s;
                     cnt_d            = CW'(MUL_CYCLES);
                     state_d          = S_BUSY;
                  end
                  OP_MULTU: begin
                     {hi_n_d, lo_n_d} = prod_u;
                     cnt_d            = CW'(MUL_CYCLES);
                     state_d          = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     hi_n_d  = div_rem;
                     lo_n_d  = div_quot;
                     cnt_d   = CW'(DIV_CYCLES);
                     state_d = S_BUSY;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            // Start is ignored here; only the countdown advances.
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               hi_d    = hi_n_q;
               lo_d    = lo_n_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_n_q  <= 32'd0;
         lo_n_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_n_q  <= hi_n_d;
         lo_n_q  <= lo_n_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (CHK_START_BUSY && !Reset && (state_q == S_BUSY)) begin
         assert (!Start)
         else $error("md_unit: Start presented while Busy");
      end
   end

   assign Busy     = (state_q == S_BUSY);
   assign StallReq = Busy | md_start;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit

module tb_md_unit;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        StallReq;
   logic [31:0] HI;
   logic [31:0] LO;

   md_unit #(
      .MUL_CYCLES     (5),
      .DIV_CYCLES     (10),
      .CHK_START_BUSY (1'b0)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Op       (Op),
      .A        (A),
      .B        (B),
      .Busy     (Busy),
      .StallReq (StallReq),
      .HI       (HI),
      .LO       (LO)
   );

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;   // expected Busy cycles; -1 for an immediate check
   } exp_t;

   exp_t sb[$];

   int   total = 0;
   int   bad   = 0;
   logic chk_evt = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endfunction

   // Monitor: pops the scoreboard when an op completes (Busy falls outside
   // reset) or when the stimulus requests an immediate check.
   logic busy_prev  = 1'b0;
   logic reset_prev = 1'b1;
   int   busy_cnt   = 0;

   always @(negedge Clk) begin
      exp_t e;
      if (Busy === 1'b1) begin
         if (!busy_prev) busy_cnt = 1;
         else            busy_cnt++;
      end
      if ((busy_prev && (Busy === 1'b0) && !reset_prev) || chk_evt) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got output event with no expectation");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, HI, e.hi);
            chk({e.name, "_lo"}, LO, e.lo);
            if (e.len >= 0) chk({e.name, "_len"}, busy_cnt, e.len);
            else            chk({e.name, "_idle"}, {31'd0, Busy}, 32'd0);
         end
         busy_cnt = 0;
      end
      busy_prev  = (Busy === 1'b1);
      reset_prev = Reset;
   end

   task automatic check_now(string name, logic [31:0] hi, logic [31:0] lo);
      sb.push_back('{name, hi, lo, -1});
      chk_evt = 1'b1;
      @(negedge Clk);
      #1 chk_evt = 1'b0;
   endtask

   task automatic check_stall(string name, logic expv);
      chk(name, {31'd0, StallReq}, {31'd0, expv});
   endtask

   task automatic wait_idle(string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Busy === 1'b0) break;
      end
      chk({"timeout_", name}, {31'd0, Busy}, 32'd0);
   endtask

   task automatic run_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] hi, logic [31:0] lo, int len);
      sb.push_back('{name, hi, lo, len});
      @(posedge Clk);
      #1 Start = 1'b1; Op = op; A = a; B = b;
      @(negedge Clk);
      check_stall({"stall_", name}, 1'b1);
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      wait_idle(name);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      check_now("reset", 32'h0, 32'h0);
      check_stall("stall_reset", 1'b0);

      run_op("mult",     3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
      run_op("multu",    3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5);
      run_op("div_neg",  3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      run_op("div_nb",   3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
      run_op("div_ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
      run_op("div_z",    3'd3, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 10);
      run_op("divu_z",   3'd4, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 10);

      // MTHI then MTLO back-to-back
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd5; A = 32'h1234;
      @(negedge Clk);
      check_stall("stall_mthi", 1'b0);
      @(posedge Clk);
      #1 Op = 3'd6; A = 32'h5678;
      check_now("mthi", 32'h1234, 32'hFFFF_FFFF);
      check_stall("stall_mtlo", 1'b0);
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      check_now("mtlo", 32'h1234, 32'h5678);

      // Op 0 and Op 7 with Start have no effect
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd0; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      @(negedge Clk);
      check_stall("stall_op0", 1'b0);
      @(posedge Clk);
      #1 Op = 3'd7;
      @(negedge Clk);
      check_stall("stall_op7", 1'b0);
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      check_now("op0_op7", 32'h1234, 32'h5678);

      // Start while Busy is ignored: MULTU 6*7 completes with its own result
      sb.push_back('{"ignore", 32'h0, 32'h2A, 5});
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd2; A = 32'd6; B = 32'd7;
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      @(negedge Clk);
      check_stall("stall_busy", 1'b1);
      @(posedge Clk);
      #1 Op = 3'd5; A = 32'hDEAD;
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      wait_idle("ignore");

      // Reset aborts an in-flight DIVU
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd5; A = 32'hABCD;
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      check_now("pre_abort", 32'hABCD, 32'h2A);
      @(posedge Clk);
      #1 Start = 1'b1; Op = 3'd4; A = 32'd100; B = 32'd3;
      @(posedge Clk);
      #1 Start = 1'b0; Op = 3'd0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      check_now("abort", 32'h0, 32'h0);
      repeat (12) @(posedge Clk);
      #1;
      check_now("abort_hold", 32'h0, 32'h0);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end

endmodule
